// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus target: FSM state encoding, default
// geometry/timing constants and the even-parity helper used when the
// SRAM_TARGET_PARITY_EN build option is defined.
package sram_bus_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 7;
    localparam int WAIT_STATES_DEF = 2;

    // One-hot encoding; any other pattern is treated as illegal and recovers to IDLE.
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        WAIT   = 4'b0010,
        ACCESS = 4'b0100,
        HOLD   = 4'b1000
    } state_e;

    // Even parity over up to 64 bits; callers zero-extend, which does not change the XOR.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sram_target_array.sv
// Storage array for the SRAM bus target: synchronous write, combinational
// read, no reset so contents survive a controller reset. With
// SRAM_TARGET_PARITY_EN defined each word carries one extra parity bit.
module sram_target_array
    import sram_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_TARGET_PARITY_EN
    input  logic              wpar,
    output logic              rpar,
`endif
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef SRAM_TARGET_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem_q [DEPTH];

    // Commit a word on a write strobe; the top only strobes for in-range writes.
    always_ff @(posedge clk) begin
        if (we) begin
`ifdef SRAM_TARGET_PARITY_EN
            mem_q[addr] <= {wpar, wdata};
`else
            mem_q[addr] <= wdata;
`endif
        end
    end

    assign rdata = mem_q[addr][DATA_W-1:0];
`ifdef SRAM_TARGET_PARITY_EN
    assign rpar  = mem_q[addr][DATA_W];
`endif

endmodule

// File: rtl/sram_bus_target.sv
// SRAM bus target (responder). Captures a cs-qualified request, waits
// WAIT_STATES cycles, performs one array access, then holds ready until the
// initiator releases cs. Build option SRAM_TARGET_PARITY_EN adds a stored
// parity bit whose mismatch on read raises err.
//
// Handshake: a request is a posedge sampling cs=0 while idle; the response is
// ready=1 (with err valid) held from the access until the first posedge that
// samples cs=1. A cs=1 edge during the wait phase abandons the request with no
// memory change and no ready. Another request needs at least one cs=1 edge.
module sram_bus_target
    import sram_bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              oe,
    input  logic              rw,
    input  logic [31:0]       addr_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              ready,
    output logic              err,
    output state_e            dbg_state
);

    localparam int WS_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_e            state_q, state_d;
    logic [WS_W-1:0]   ws_q, ws_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              rw_q, rw_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              par_bad;

`ifdef SRAM_TARGET_PARITY_EN
    logic wpar;
    logic rpar;
    assign wpar    = even_parity(64'(wdata_q));
    assign par_bad = rpar ^ even_parity(64'(mem_rdata));
`else
    assign par_bad = 1'b0;
`endif

    sram_target_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (a_q),
        .wdata(wdata_q),
`ifdef SRAM_TARGET_PARITY_EN
        .wpar (wpar),
        .rpar (rpar),
`endif
        .rdata(mem_rdata)
    );

    // Next-state and datapath decisions for the request/wait/access/hold sequence.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        a_d     = a_q;
        rw_d    = rw_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs) begin
                    a_d   = addr_bus[ADDR_W-1:0];
                    rw_d  = rw;
                    oor_d = |addr_bus[31:ADDR_W];
                    ws_d  = '0;
                    if (!rw) begin
                        wdata_d = data_bus;
                    end
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cs) begin
                    state_d = IDLE;
                end else if (ws_q == WS_W'(WAIT_STATES - 1)) begin
                    state_d = ACCESS;
                end else begin
                    ws_d = ws_q + WS_W'(1);
                end
            end
            ACCESS: begin
                // Out-of-range requests never touch the array and read back as zero.
                mem_we = !rw_q && !oor_q;
                if (rw_q) begin
                    rdata_d = oor_q ? '0 : mem_rdata;
                end
                err_d   = oor_q || (rw_q && par_bad);
                ready_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (cs) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Register all controller state; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ws_q    <= '0;
            a_q     <= '0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            a_q     <= a_d;
            rw_q    <= rw_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Drive only for a held read while the initiator is still asking for it.
    assign data_bus  = (state_q == HOLD && rw_q && !cs && !oe && rw) ? rdata_q : 'z;
    assign ready     = ready_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_bus_target.sv
// Bench for sram_bus_target: directed scenarios plus random traffic, checked
// by a scoreboard fed from a word-array reference model.
module tb_sram_bus_target;
    import sram_bus_pkg::*;

    localparam int WS    = 2;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, oe, rw;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        ready, err;
    state_e      dbg_state;

    logic        drv_en;
    logic [31:0] drv_val;
    assign data_bus = drv_en ? drv_val : 'z;

    int n_checks = 0;
    int n_fail   = 0;

    // expected entry: {check_data, is_read, err, data}
    logic [34:0] exp_q[$];

    logic [31:0] model_mem [DEPTH];
    bit          model_vld [DEPTH];

    // ---------------- clock/reset ----------------
    always #5 clk = ~clk;

    sram_bus_target #(
        .DATA_W(32),
        .ADDR_W(7),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .oe       (oe),
        .rw       (rw),
        .addr_bus (addr_bus),
        .data_bus (data_bus),
        .ready    (ready),
        .err      (err),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model + driver ----------------
    task automatic push_expect(input logic [31:0] addr, input bit rd, input logic [31:0] wd);
        bit          oor;
        logic [31:0] d;
        bit          chk;
        oor = (addr >= DEPTH);
        d   = '0;
        chk = 1'b0;
        if (rd) begin
            if (oor) begin
                chk = 1'b1;
            end else begin
                d   = model_mem[addr];
                chk = model_vld[addr];
            end
        end else if (!oor) begin
            model_mem[addr] = wd;
            model_vld[addr] = 1'b1;
        end
        exp_q.push_back({chk, rd, oor, d});
    endtask

    task automatic do_txn(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                          input bit rst_in_hold);
        int          cyc;
        logic [31:0] rd_exp;
        rd_exp = (addr < DEPTH) ? model_mem[addr] : '0;
        push_expect(addr, rd, wd);
        @(posedge clk); #2;
        cs = 1'b0; rw = rd; oe = !rd; addr_bus = addr;
        drv_en = !rd; drv_val = wd;
        @(posedge clk); #1;
        cyc = 0;
        while (!ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(WS + 1));
        // Request inputs change while held; the response must not follow them.
        addr_bus = $urandom;
        if (!rd) drv_val = $urandom;
        if (rst_in_hold) begin
            @(negedge clk); #1;
            reset = 1'b1;
            #1;
            check("rst_ready", 64'(ready), 64'(0));
            check("rst_err", 64'(err), 64'(0));
            n_checks++;
            if (data_bus === rd_exp) begin
                n_fail++;
                $display("FAIL rst_bus: got %0h still driven, required released", data_bus);
            end
            @(posedge clk); #2;
            reset = 1'b0;
            cs = 1'b1; oe = 1'b1; drv_en = 1'b0;
        end else begin
            @(posedge clk); #2;
            cs = 1'b1; oe = 1'b1; drv_en = 1'b0;
        end
        @(posedge clk); #1;
        check("ready_release", 64'(ready), 64'(0));
    endtask

    // Request then withdraw cs during the wait phase; no response may appear.
    task automatic do_abort(input logic [31:0] addr, input logic [31:0] wd);
        int seen;
        @(posedge clk); #2;
        cs = 1'b0; rw = 1'b0; oe = 1'b1; addr_bus = addr; drv_en = 1'b1; drv_val = wd;
        @(posedge clk);
        @(posedge clk); #2;
        cs = 1'b1; drv_en = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("abort_no_ready", 64'(seen), 64'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic        prev_ready;
        logic [34:0] e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1 required no response");
                end else begin
                    e = exp_q.pop_front();
                    check("err", 64'(err), 64'(e[32]));
                    if (e[34] && e[33]) check("rdata", 64'(data_bus), 64'(e[31:0]));
                end
            end
            prev_ready = ready;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        bit          rd;
        for (int i = 0; i < DEPTH; i++) begin
            model_vld[i] = 1'b0;
            model_mem[i] = '0;
        end
        reset = 1'b1; cs = 1'b1; oe = 1'b1; rw = 1'b1; addr_bus = '0;
        drv_en = 1'b0; drv_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        #1 reset = 1'b0;

        // write then read back
        do_txn(32'd0, 1'b0, 32'd127, 1'b0);
        do_txn(32'd0, 1'b1, 32'd0, 1'b0);

        // fill whole array and read it back, including the top address
        for (int i = 0; i < DEPTH; i++) do_txn(32'(i), 1'b0, 32'(127 - i), 1'b0);
        for (int i = 0; i < DEPTH; i++) do_txn(32'(i), 1'b1, 32'd0, 1'b0);

        // out-of-range: no aliasing into address 0, reads return zero with err
        do_txn(32'h80, 1'b0, 32'd5, 1'b0);
        do_txn(32'd0, 1'b1, 32'd0, 1'b0);
        do_txn(32'h80, 1'b1, 32'd0, 1'b0);
        do_txn(32'h8000_0001, 1'b0, 32'hdead, 1'b0);
        do_txn(32'd1, 1'b1, 32'd0, 1'b0);

        // abort during wait leaves prior contents
        do_abort(32'd3, 32'hAA);
        do_txn(32'd3, 1'b1, 32'd0, 1'b0);

        // reset while a read is held; contents survive
        do_txn(32'd0, 1'b1, 32'd0, 1'b1);
        do_txn(32'd0, 1'b1, 32'd0, 1'b0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h80 + 32'($urandom_range(0, 4000));
            else a = 32'($urandom_range(0, DEPTH - 1));
            rd = ($urandom_range(0, 1) == 1);
            do_txn(a, rd, $urandom, 1'b0);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
